// File: rtl/ls_pkg.sv
// Shared types and widths for the load/store address generation unit.
package ls_pkg;

  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned DATA_W         = 16;
  localparam int unsigned INDX_W         = 6;
  localparam int unsigned PHY_W          = 6;
  localparam int unsigned IMM_W          = 8;
  localparam int unsigned AGU_FIFO_DEPTH = 2;
  localparam int unsigned CNT_W          = $clog2(AGU_FIFO_DEPTH + 1);
  localparam int unsigned PTR_W          = $clog2(AGU_FIFO_DEPTH);

  typedef struct packed {
    logic              is_ld;
    logic              is_str;
    logic [INDX_W-1:0] indx;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [PHY_W-1:0]  phy;
  } agu_entry_t;

  // Effective address: base plus sign-extended byte offset, carry dropped.
  function automatic logic [ADDR_W-1:0] agu_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [IMM_W-1:0]  imm);
    return base + {{(ADDR_W - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/ls_agu_fifo.sv
// Two-entry circular output FIFO for the AGU; head entry is always visible.
module ls_agu_fifo
  import ls_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  agu_entry_t       push_data_i,
  input  logic             pop_i,
  output agu_entry_t       head_o,
  output logic [CNT_W-1:0] count_o
);

  agu_entry_t       mem_q [AGU_FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Caller only pops when non-empty and only pushes into a free (or freed) slot.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      count_d = count_q + {{(CNT_W-1){1'b0}}, push_i} - {{(CNT_W-1){1'b0}}, pop_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < AGU_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ls_agu.sv
// Load/store AGU: address adder, one issue register (S1) and a 2-entry output FIFO.
// Optional AGU_FAST_PATH_EN lets S1 strobe directly when the FIFO is empty.
module ls_agu
  import ls_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_vld,
  input  logic              iss_ld,
  input  logic              iss_str,
  input  logic [INDX_W-1:0] iss_indx,
  input  logic [ADDR_W-1:0] iss_base,
  input  logic [IMM_W-1:0]  iss_imm,
  input  logic [DATA_W-1:0] iss_data,
  input  logic [PHY_W-1:0]  iss_phy,
  input  logic              flsh,
  input  logic              stll,
  output logic              iss_rdy,
  output logic              mem_rd,
  output logic              mem_wrt,
  output logic [INDX_W-1:0] indx_ls,
  output logic [ADDR_W-1:0] addr_ls,
  output logic [DATA_W-1:0] data_str,
  output logic [PHY_W-1:0]  phy_addr_ld_in
);

  logic             s1_vld_q, s1_vld_d;
  agu_entry_t       s1_q, s1_d;
  agu_entry_t       head;
  agu_entry_t       out_e;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             fifo_push;
  logic             fifo_pop;
  logic             bypass;

  assign iss_rdy = ({1'b0, count} + {{CNT_W{1'b0}}, s1_vld_q}) < (CNT_W + 1)'(AGU_FIFO_DEPTH);

  always_comb begin
    accept   = iss_vld & iss_rdy & (iss_ld ^ iss_str) & ~flsh;
    fifo_pop = (count != '0) & ~stll & ~flsh;
`ifdef AGU_FAST_PATH_EN
    bypass   = (count == '0) & s1_vld_q & ~stll & ~flsh;
`else
    bypass   = 1'b0;
`endif
    // S1 may refill the slot freed by a same-cycle pop.
    fifo_push = s1_vld_q & ~bypass & ~flsh &
                ((count < CNT_W'(AGU_FIFO_DEPTH)) | fifo_pop);

    s1_vld_d = s1_vld_q;
    s1_d     = s1_q;
    if (fifo_push || bypass) begin
      s1_vld_d = 1'b0;
    end
    if (accept) begin
      s1_vld_d = 1'b1;
      s1_d     = '{is_ld:  iss_ld,
                   is_str: iss_str,
                   indx:   iss_indx,
                   addr:   agu_addr(iss_base, iss_imm),
                   data:   iss_data,
                   phy:    iss_phy};
    end
    if (flsh) begin
      s1_vld_d = 1'b0;
    end

    out_e          = bypass ? s1_q : head;
    mem_rd         = (fifo_pop | bypass) & out_e.is_ld;
    mem_wrt        = (fifo_pop | bypass) & out_e.is_str;
    indx_ls        = out_e.indx;
    addr_ls        = out_e.addr;
    data_str       = out_e.data;
    phy_addr_ld_in = out_e.phy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_q     <= s1_d;
    end
  end

  ls_agu_fifo u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flsh),
    .push_i      (fifo_push),
    .push_data_i (s1_q),
    .pop_i       (fifo_pop),
    .head_o      (head),
    .count_o     (count)
  );

endmodule

// File: tb/tb_ls_agu.sv
// Self-checking bench for ls_agu: queue-level reference model plus directed scenarios.
module tb_ls_agu;
  import ls_pkg::*;

`ifdef AGU_FAST_PATH_EN
  localparam int Lat = 1;
`else
  localparam int Lat = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_vld = 1'b0, iss_ld = 1'b0, iss_str = 1'b0;
  logic [5:0]  iss_indx = '0, iss_phy = '0;
  logic [15:0] iss_base = '0, iss_data = '0;
  logic [7:0]  iss_imm = '0;
  logic        flsh = 1'b0, stll = 1'b0;
  logic        iss_rdy, mem_rd, mem_wrt;
  logic [5:0]  indx_ls, phy_addr_ld_in;
  logic [15:0] addr_ls, data_str;

  int n_chk = 0;
  int n_fail = 0;
  logic [5:0] seen[$];

  ls_agu dut (
    .clk            (clk),
    .rst            (rst),
    .iss_vld        (iss_vld),
    .iss_ld         (iss_ld),
    .iss_str        (iss_str),
    .iss_indx       (iss_indx),
    .iss_base       (iss_base),
    .iss_imm        (iss_imm),
    .iss_data       (iss_data),
    .iss_phy        (iss_phy),
    .flsh           (flsh),
    .stll           (stll),
    .iss_rdy        (iss_rdy),
    .mem_rd         (mem_rd),
    .mem_wrt        (mem_wrt),
    .indx_ls        (indx_ls),
    .addr_ls        (addr_ls),
    .data_str       (data_str),
    .phy_addr_ld_in (phy_addr_ld_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ops wait one cycle in an issue slot, then queue (max 2) in order.
  agu_entry_t m_q[$];
  agu_entry_t m_s1;
  agu_entry_t m_e;
  bit         m_s1v = 0;
  bit         m_live = 0;
  bit         m_rdy, m_pop, m_fp;

  always @(negedge clk) begin
    if (rst) begin
      m_q.delete();
      m_s1v  = 0;
      m_live = 1;
    end else if (m_live) begin
      m_rdy = (m_q.size() + int'(m_s1v)) < 2;
      chk("model_iss_rdy", iss_rdy, m_rdy);
      m_pop = 0;
      m_fp  = 0;
      m_e   = '0;
      if (!flsh && !stll) begin
        if (m_q.size() > 0) begin
          m_pop = 1;
          m_e   = m_q[0];
        end
`ifdef AGU_FAST_PATH_EN
        else if (m_s1v) begin
          m_fp = 1;
          m_e  = m_s1;
        end
`endif
      end
      chk("model_mem_rd", mem_rd, (m_pop || m_fp) && m_e.is_ld);
      chk("model_mem_wrt", mem_wrt, (m_pop || m_fp) && m_e.is_str);
      if (m_pop || m_fp) begin
        chk("model_indx", indx_ls, m_e.indx);
        chk("model_addr", addr_ls, m_e.addr);
        if (m_e.is_str) chk("model_data", data_str, m_e.data);
        if (m_e.is_ld) chk("model_phy", phy_addr_ld_in, m_e.phy);
      end
      if (flsh) begin
        m_q.delete();
        m_s1v = 0;
      end else begin
        if (m_pop) void'(m_q.pop_front());
        if (m_fp) m_s1v = 0;
        else if (m_s1v && m_q.size() < 2) begin
          m_q.push_back(m_s1);
          m_s1v = 0;
        end
        if (iss_vld && m_rdy && (iss_ld ^ iss_str)) begin
          m_s1v = 1;
          m_s1 = '{is_ld: iss_ld, is_str: iss_str, indx: iss_indx,
                   addr: iss_base + 16'($signed(iss_imm)), data: iss_data, phy: iss_phy};
        end
      end
    end
  end

  task automatic drive(input logic v, input logic ld, input logic st, input logic [5:0] ix,
                       input logic [15:0] b, input logic [7:0] im, input logic [15:0] d,
                       input logic [5:0] ph);
    @(posedge clk);
    #1;
    iss_vld = v; iss_ld = ld; iss_str = st; iss_indx = ix;
    iss_base = b; iss_imm = im; iss_data = d; iss_phy = ph;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 16'h0, 8'h0, 16'h0, 6'd0);
  endtask

  task automatic collect(input int n);
    repeat (n) begin
      @(negedge clk);
      if (mem_rd || mem_wrt) seen.push_back(indx_ls);
    end
  endtask

  // Present an op until accepted; a stalled queue is released so the wait is bounded.
  task automatic issue_wait(input logic ld, input logic st, input logic [5:0] ix,
                            input logic [15:0] b, input logic [7:0] im, input logic [15:0] d,
                            input logic [5:0] ph, input logic stall);
    bit ok = 0;
    drive(1'b1, ld, st, ix, b, im, d, ph);
    stll = stall;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (iss_rdy) ok = 1;
      else begin
        @(posedge clk);
        #1;
        stll = 1'b0;
      end
    end
    chk("issue_accept_timeout", ok, 1);
  endtask

  logic [15:0] st_base [6] = '{16'h0010, 16'h2000, 16'hFFF0, 16'h0100, 16'h8000, 16'h0003};
  logic [7:0]  st_imm  [6] = '{8'h7F,    8'h80,    8'h20,    8'hFF,    8'h01,    8'hFD};
  logic [5:0]  stall_pat = 6'b010110;

  initial begin
    bit ok;
    // Reset state
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_iss_rdy", iss_rdy, 1);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wrt", mem_wrt, 0);
    chk("rst_indx", indx_ls, 0);
    chk("rst_addr", addr_ls, 0);
    chk("rst_data", data_str, 0);
    chk("rst_phy", phy_addr_ld_in, 0);

    // Load 0x1000 + (-4) -> 0x0FFC
    drive(1'b1, 1'b1, 1'b0, 6'd5, 16'h1000, 8'hFC, 16'h0, 6'd12);
    @(negedge clk);
    for (int i = 1; i <= 2; i++) begin
      idle();
      @(negedge clk);
      chk("ld_strobe", mem_rd, i == Lat);
      if (i == Lat) begin
        chk("ld_addr", addr_ls, 16'h0FFC);
        chk("ld_indx", indx_ls, 5);
        chk("ld_phy", phy_addr_ld_in, 12);
      end
    end

    // Store wrap 0xFFFF + 1 -> 0x0000
    drive(1'b1, 1'b0, 1'b1, 6'd9, 16'hFFFF, 8'h01, 16'hBEEF, 6'd0);
    @(negedge clk);
    for (int i = 1; i <= 2; i++) begin
      idle();
      @(negedge clk);
      chk("st_strobe", mem_wrt, i == Lat);
      if (i == Lat) begin
        chk("st_addr", addr_ls, 16'h0000);
        chk("st_data", data_str, 16'hBEEF);
      end
    end

    // Back-to-back under stall
    seen.delete();
    drive(1'b1, 1'b1, 1'b0, 6'd1, 16'h0100, 8'h00, 16'h0, 6'd1);
    stll = 1'b1;
    @(negedge clk);
    chk("b2b_rdy0", iss_rdy, 1);
    drive(1'b1, 1'b0, 1'b1, 6'd2, 16'h0200, 8'h04, 16'h1234, 6'd0);
    @(negedge clk);
    chk("b2b_rdy1", iss_rdy, 1);
    drive(1'b1, 1'b1, 1'b0, 6'd3, 16'h0300, 8'hF8, 16'h0, 6'd3);
    @(negedge clk);
    chk("b2b_rdy_drop", iss_rdy, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    stll = 1'b0;
    ok = 0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge clk);
      if (mem_rd || mem_wrt) seen.push_back(indx_ls);
      if (iss_rdy) ok = 1;
    end
    chk("b2b_third_accept", ok, 1);
    idle();
    collect(6);
    chk("b2b_count", seen.size(), 3);
    chk("b2b_order0", seen[0], 1);
    chk("b2b_order1", seen[1], 2);
    chk("b2b_order2", seen[2], 3);

    // Illegal op: both load and store set
    seen.delete();
    drive(1'b1, 1'b1, 1'b1, 6'd20, 16'h4000, 8'h00, 16'h0, 6'd7);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("illegal_rdy", iss_rdy, 1);
    collect(4);
    chk("illegal_no_strobe", seen.size(), 0);

    // Mixed stream with intermittent stall, checked by the model
    for (int k = 0; k < 6; k++) begin
      issue_wait(k[0], ~k[0], 6'(32 + k), st_base[k], st_imm[k], 16'(16'hA000 + k),
                 6'(40 + k), stall_pat[k]);
    end
    idle();
    stll = 1'b0;
    collect(8);

    // Flush with two queued ops
    seen.delete();
    drive(1'b1, 1'b1, 1'b0, 6'd7, 16'h0700, 8'h00, 16'h0, 6'd7);
    stll = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 6'd8, 16'h0800, 8'h00, 16'h5555, 6'd0);
    idle();
    idle();
    drive(1'b1, 1'b1, 1'b0, 6'd9, 16'h0900, 8'h00, 16'h0, 6'd9);
    stll = 1'b0;
    flsh = 1'b1;
    @(negedge clk);
    chk("flush_no_strobe", mem_rd | mem_wrt, 0);
    idle();
    flsh = 1'b0;
    @(negedge clk);
    chk("flush_rdy", iss_rdy, 1);
    collect(5);
    chk("flush_no_late_strobe", seen.size(), 0);

    // Reset with the queue full
    seen.delete();
    drive(1'b1, 1'b1, 1'b0, 6'd10, 16'h0A00, 8'h00, 16'h0, 6'd10);
    stll = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 6'd11, 16'h0B00, 8'h00, 16'hCAFE, 6'd0);
    idle();
    idle();
    idle();
    rst = 1'b1;
    @(negedge clk);
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_mem_rd", mem_rd, 0);
    chk("rst2_mem_wrt", mem_wrt, 0);
    chk("rst2_addr", addr_ls, 0);
    chk("rst2_data", data_str, 0);
    chk("rst2_indx", indx_ls, 0);
    chk("rst2_rdy", iss_rdy, 1);
    idle();
    stll = 1'b0;
    collect(4);
    chk("rst2_no_strobe", seen.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ls_agu.md
LS_AGU -- requirements
Module: ls_agu

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 iss_vld  input  1  issue stage presents a memory op this cycle.
REQ-004 iss_ld / iss_str  input  1 each  op is a load / store.
REQ-005 iss_indx  input  6  LSQ index of the op.
REQ-006 iss_base  input  16  base register value.
REQ-007 iss_imm  input  8  signed byte offset.
REQ-008 iss_data  input  16  store data; ignored for loads.
REQ-009 iss_phy  input  6  destination physical register; ignored for stores.
REQ-010 flsh  input  1  misprediction; kill all in-flight ops.
REQ-011 stll  input  1  LSQ full; hold output.
REQ-012 iss_rdy  output  1  AGU accepts an op this cycle.
REQ-013 mem_rd / mem_wrt  output  1 each  one-cycle strobe per delivered load / store.
REQ-014 indx_ls  output  6; addr_ls  output  16; data_str  output  16; phy_addr_ld_in  output  6  payload qualified by mem_rd | mem_wrt.

Function
REQ-015 Accept when iss_vld & iss_rdy & (iss_ld ^ iss_str); iss_ld & iss_str together or neither set: op dropped, no state change.
REQ-016 addr = iss_base + sign-extended iss_imm, 16-bit, carry discarded (0xFFFF + 1 = 0x0000; 0x0000 + (-1) = 0xFFFF).
REQ-017 Stage S1: one register (s1_vld + payload) loaded on accept; moves into output FIFO next cycle.
REQ-018 Output FIFO: 2 entries, circular 1-bit pointers with wrap, count 0..2; head drives outputs.
REQ-019 iss_rdy = (count + s1_vld) < 2, combinational from registered state.
REQ-020 Pop when count > 0 & !stll & !flsh; mem_rd = pop & head.is_ld, mem_wrt = pop & head.is_str.
REQ-021 stll high: no pop, strobes low, payload outputs hold head value; S1 still drains into FIFO if count < 2.
REQ-022 Simultaneous S1 push and pop with count = 2: pop first, push into freed slot; count stays 2.
REQ-023 Latency without fast path: accept in cycle N -> strobe in cycle N+2 when no stall.
REQ-024 Order: strict issue order; no reordering or merging.
REQ-025 flsh high: S1 and FIFO cleared at the clock edge (count=0, pointers=0); strobes low that cycle; op presented in the flush cycle is discarded.
REQ-026 Payload outputs when no strobe: hold last head value (not required to be zero).

Reset
REQ-027 rst: s1_vld=0, count=0, pointers=0, mem_rd=0, mem_wrt=0, indx_ls=0, addr_ls=0, data_str=0, phy_addr_ld_in=0; iss_rdy=1 in the first cycle after reset.
REQ-028 rst overrides flsh and accept in the same cycle; in-flight ops are lost.

Configuration
REQ-029 Macro AGU_FAST_PATH_EN defined: when count = 0, s1_vld and !stll, S1 drives the outputs directly and strobes; the FIFO is bypassed, giving latency N+1.
REQ-030 AGU_FAST_PATH_EN undefined: all ops pass through the FIFO; latency fixed at N+2 (REQ-023).

Structure
REQ-031 Shared package ls_pkg: ADDR_W=16, DATA_W=16, INDX_W=6, PHY_W=6, IMM_W=8, AGU_FIFO_DEPTH=2, and the entry struct {is_ld, is_str, indx, addr, data, phy}.
REQ-032 Sub-module ls_agu_fifo (2-entry FIFO with count/pointers); the adder and S1 stay in ls_agu.

Verification
REQ-033 Load: base=0x1000, imm=0xFC, indx=5, phy=12 -> without fast path, mem_rd at N+2 with addr_ls=0x0FFC, indx_ls=5, phy_addr_ld_in=12; with AGU_FAST_PATH_EN, same at N+1.
REQ-034 Wrap: store base=0xFFFF, imm=0x01, data=0xBEEF -> mem_wrt with addr_ls=0x0000, data_str=0xBEEF.
REQ-035 Back-to-back: 3 ops issued with stll=1 -> iss_rdy drops after the 2nd accept; release stll -> 3 strobes in issue order, 1 per cycle, no loss.
REQ-036 Flush: 2 ops queued, flsh pulse -> no strobes afterwards, count=0, iss_rdy=1 next cycle.
REQ-037 Illegal: iss_vld with iss_ld=iss_str=1 -> no strobe ever, iss_rdy unchanged.
REQ-038 Reset mid-stream: rst asserted with FIFO full -> all outputs 0 next cycle, no strobes from old ops.
